// File: rtl/dcache_coherence_agent.sv
// Per-CPU MSI data-cache coherence agent: 16-set direct-mapped cache with two-word blocks.
// Latency: load/store hits complete in 0 cycles (combinational dhit in IDLE). A clean miss
// costs 1 cycle + 2 bus words + 1 hit cycle; a dirty miss adds 2 writeback words.
// Backpressure: bus beats advance only when dwait is low; the CPU holds its request until dhit.
// Snoops take priority over CPU requests and may abort a WB0/FILL0 that has not finished a word.
//
// Ports:
//   CLK, RST                         clock and synchronous active-high reset
//   dmemREN/dmemWEN/dmemaddr/dmemstore  CPU request (REN+WEN together is treated as a store)
//   dhit/dmemload                    CPU completion and load data
//   dREN/dWEN/daddr/dstore/dwait/dload  memory bus (fills and writebacks)
//   ccwait/ccsnoopaddr/ccinv         snoop request from the coherence controller
//   cctrans/ccwrite                  snoop response / read-exclusive marker on fills
module dcache_coherence_agent #(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  input  logic        ccwait,
  input  logic [31:0] ccsnoopaddr,
  input  logic        ccinv,
  output logic        cctrans,
  output logic        ccwrite
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = 32 - 3 - IW;

  typedef enum logic [1:0] {F_I, F_S, F_M} fstate_t;
  typedef enum logic [2:0] {IDLE, SNOOP, SWB0, SWB1, WB0, WB1, FILL0, FILL1} state_t;

  // Frame storage: only the coherence state is reset; tags/data are don't-care while I.
  fstate_t         fst  [NSETS];
  logic [TW-1:0]   ftag [NSETS];
  logic [31:0]     fw0  [NSETS];
  logic [31:0]     fw1  [NSETS];

  state_t          state;
  logic [31:0]     snp_addr;   // snoop address captured on SNOOP entry
  logic            snp_inv;    // snoop invalidate flag captured on SNOOP entry
  logic [31:0]     fill_w0;    // first fill word, held until the block installs

  // CPU request lookup
  logic [IW-1:0]   ridx;
  logic [TW-1:0]   rtag;
  logic            rtag_match;
  logic            rvalid;
  logic            is_store;
  logic            is_load;
  logic            load_hit;
  logic            store_hit;
  logic            need_fill;
  logic            victim_dirty;
  logic [31:0]     rd_word;

  assign ridx         = dmemaddr[3 +: IW];
  assign rtag         = dmemaddr[31 -: TW];
  assign rtag_match   = (ftag[ridx] == rtag);
  assign rvalid       = (fst[ridx] != F_I);
  assign is_store     = dmemWEN;
  assign is_load      = dmemREN & ~dmemWEN;
  assign load_hit     = is_load & rvalid & rtag_match;
  // A store to an S block is an upgrade and must go to the bus for exclusivity.
  assign store_hit    = is_store & rtag_match & (fst[ridx] == F_M);
  assign need_fill    = (dmemREN | dmemWEN) & ~(load_hit | store_hit);
  assign victim_dirty = (fst[ridx] == F_M) & ~rtag_match;
  assign rd_word      = dmemaddr[2] ? fw1[ridx] : fw0[ridx];

  // Snoop lookup, always against the captured snoop address
  logic [IW-1:0]   sidx;
  logic            s_hit;
  logic            s_m;

  assign sidx  = snp_addr[3 +: IW];
  assign s_hit = (fst[sidx] != F_I) && (ftag[sidx] == snp_addr[31 -: TW]);
  assign s_m   = s_hit && (fst[sidx] == F_M);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmemaddr[1:0], snp_addr[2:0]};

  // Outputs are decoded from state so they stay stable while dwait is high.
  always_comb begin
    dhit     = 1'b0;
    dmemload = 32'h0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'h0;
    dstore   = 32'h0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    case (state)
      IDLE: begin
        if (!ccwait) begin
          dhit     = load_hit | store_hit;
          dmemload = load_hit ? rd_word : 32'h0;
        end
      end
      SNOOP: begin
        cctrans = 1'b1;
        ccwrite = s_m;
      end
      SWB0: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        dWEN    = 1'b1;
        daddr   = {snp_addr[31:3], 3'b000};
        dstore  = fw0[sidx];
      end
      SWB1: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        dWEN    = 1'b1;
        daddr   = {snp_addr[31:3], 3'b100};
        dstore  = fw1[sidx];
      end
      WB0: begin
        // A pending snoop drops the bus request immediately (abort).
        if (!ccwait) begin
          dWEN   = 1'b1;
          daddr  = {ftag[ridx], ridx, 3'b000};
          dstore = fw0[ridx];
        end
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = {ftag[ridx], ridx, 3'b100};
        dstore = fw1[ridx];
      end
      FILL0: begin
        if (!ccwait) begin
          dREN    = 1'b1;
          daddr   = {dmemaddr[31:3], 3'b000};
          ccwrite = dmemWEN;
        end
      end
      FILL1: begin
        dREN    = 1'b1;
        daddr   = {dmemaddr[31:3], 3'b100};
        ccwrite = dmemWEN;
      end
      default: begin
      end
    endcase
  end

  // Control FSM plus frame coherence state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      snp_addr <= 32'h0;
      snp_inv  <= 1'b0;
      fill_w0  <= 32'h0;
      for (int i = 0; i < NSETS; i++) fst[i] <= F_I;
    end else begin
      case (state)
        IDLE: begin
          if (ccwait) begin
            state    <= SNOOP;
            snp_addr <= ccsnoopaddr;
            snp_inv  <= ccinv;
          end else if (need_fill) begin
            state <= victim_dirty ? WB0 : FILL0;
          end
        end
        SNOOP: begin
          if (s_m) begin
            state <= SWB0;
          end else begin
            if (s_hit && snp_inv) fst[sidx] <= F_I;
            state <= IDLE;
          end
        end
        SWB0: if (!dwait) state <= SWB1;
        SWB1: begin
          if (!dwait) begin
            fst[sidx] <= snp_inv ? F_I : F_S;
            state     <= IDLE;
          end
        end
        WB0: begin
          if (ccwait) begin
            state    <= SNOOP;
            snp_addr <= ccsnoopaddr;
            snp_inv  <= ccinv;
          end else if (!dwait) begin
            state <= WB1;
          end
        end
        // The victim stays M after writeback; an aborted fill simply rewrites it later.
        WB1: if (!dwait) state <= FILL0;
        FILL0: begin
          if (ccwait) begin
            state    <= SNOOP;
            snp_addr <= ccsnoopaddr;
            snp_inv  <= ccinv;
          end else if (!dwait) begin
            fill_w0 <= dload;
            state   <= FILL1;
          end
        end
        FILL1: begin
          if (!dwait) begin
            fst[ridx] <= dmemWEN ? F_M : F_S;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays; writes during reset are harmless since every frame goes I.
  always_ff @(posedge CLK) begin
    if (state == IDLE && !ccwait && store_hit) begin
      if (dmemaddr[2]) fw1[ridx] <= dmemstore;
      else             fw0[ridx] <= dmemstore;
    end
    if (state == FILL1 && !dwait) begin
      ftag[ridx] <= rtag;
      fw0[ridx]  <= (dmemWEN && !dmemaddr[2]) ? dmemstore : fill_w0;
      fw1[ridx]  <= (dmemWEN &&  dmemaddr[2]) ? dmemstore : dload;
    end
  end

endmodule

// File: tb/tb_dcache_coherence_agent.sv
// Directed bench for dcache_coherence_agent: bus beats and load results are queued
// as expectations when a request is issued and compared when the DUT produces them.
module tb_dcache_coherence_agent;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = 32'h0;
  logic [31:0] dmemstore = 32'h0;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait = 1'b1;
  logic [31:0] dload = 32'h0;
  logic        ccwait = 1'b0;
  logic [31:0] ccsnoopaddr = 32'h0;
  logic        ccinv = 1'b0;
  logic        cctrans;
  logic        ccwrite;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic        ccw;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_bus  [$];
  logic [31:0] exp_load [$];

  dcache_coherence_agent #(.NSETS(16)) dut (
    .CLK(CLK), .RST(RST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr), .ccinv(ccinv),
    .cctrans(cctrans), .ccwrite(ccwrite)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic [31:0] a, input logic ccw);
    bus_t e;
    e.wr = 1'b0; e.ccw = ccw; e.addr = a; e.data = 32'h0;
    exp_bus.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    e.wr = 1'b1; e.ccw = 1'b0; e.addr = a; e.data = d;
    exp_bus.push_back(e);
  endtask

  // Called #1 after a rising edge; issues a CPU request.
  task automatic cpu_req(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
    dmemREN = ren; dmemWEN = wen; dmemaddr = a; dmemstore = d;
  endtask

  // Wait for the next bus word, compare it with the scoreboard, then complete it.
  task automatic serve_beat(input string tag, input logic [31:0] rdata);
    bus_t e;
    int n;
    n = 0;
    @(negedge CLK);
    while (!(dREN || dWEN) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk1({tag, "_bus_req"}, dREN | dWEN, 1'b1);
    if (exp_bus.size() == 0) begin
      chk1({tag, "_bus_queue"}, 1'b0, 1'b1);
    end else begin
      e = exp_bus.pop_front();
      chk1({tag, "_bus_dir"}, dWEN, e.wr);
      chk({tag, "_daddr"}, daddr, e.addr);
      if (e.wr) chk({tag, "_dstore"}, dstore, e.data);
      else      chk1({tag, "_fill_ccwrite"}, ccwrite, e.ccw);
    end
    dwait = 1'b0;
    dload = rdata;
    @(posedge CLK);
    #1;
    dwait = 1'b1;
    dload = 32'h0;
  endtask

  // Wait for dhit, optionally compare load data, then drop the request.
  task automatic wait_hit(input string tag, input bit is_ld, output int lat);
    int n;
    n = 0;
    @(negedge CLK);
    while (!dhit && n < 40) begin
      @(negedge CLK);
      n++;
    end
    lat = n;
    chk1({tag, "_dhit"}, dhit, 1'b1);
    if (is_ld) begin
      if (exp_load.size() == 0) chk1({tag, "_load_queue"}, 1'b0, 1'b1);
      else chk({tag, "_dmemload"}, dmemload, exp_load.pop_front());
    end
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  // Snoop issued from IDLE; an M hit is followed by the two writeback words.
  task automatic snoop(input string tag, input logic [31:0] a, input logic inv, input logic exp_m);
    ccwait = 1'b1; ccsnoopaddr = a; ccinv = inv;
    @(negedge CLK);
    chk1({tag, "_cctrans_first"}, cctrans, 1'b0);
    @(negedge CLK);
    chk1({tag, "_cctrans"}, cctrans, 1'b1);
    chk1({tag, "_ccwrite"}, ccwrite, exp_m);
    ccwait = 1'b0;
    if (exp_m) begin
      @(posedge CLK);
      #1;
      serve_beat({tag, "_swb0"}, 32'h0);
      serve_beat({tag, "_swb1"}, 32'h0);
    end else begin
      @(negedge CLK);
      chk1({tag, "_cctrans_done"}, cctrans, 1'b0);
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int lat;

    // Reset: all outputs low
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk1("rst_dhit", dhit, 1'b0);
    chk1("rst_dREN", dREN, 1'b0);
    chk1("rst_dWEN", dWEN, 1'b0);
    chk1("rst_cctrans", cctrans, 1'b0);
    chk1("rst_ccwrite", ccwrite, 1'b0);
    chk("rst_daddr", daddr, 32'h0);
    chk("rst_dmemload", dmemload, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Cold load 0x40: fill 0x40/0x44 then hit with word0
    cpu_req(1'b1, 1'b0, 32'h40, 32'h0);
    push_rd(32'h40, 1'b0); push_rd(32'h44, 1'b0);
    exp_load.push_back(32'h0000AAAA);
    @(negedge CLK);
    chk1("cold_miss_dhit", dhit, 1'b0);
    @(posedge CLK);
    #1;
    serve_beat("cold_f0", 32'h0000AAAA);
    serve_beat("cold_f1", 32'h0000BBBB);
    wait_hit("cold_hit", 1'b1, lat);
    chk("cold_hit_lat", lat, 0);

    // Store 0x44 <- 0x1234 on an S block: exclusive refill, then hit
    cpu_req(1'b0, 1'b1, 32'h44, 32'h1234);
    push_rd(32'h40, 1'b1); push_rd(32'h44, 1'b1);
    serve_beat("upg_f0", 32'h0000AAAA);
    serve_beat("upg_f1", 32'h0000BBBB);
    wait_hit("upg_store", 1'b0, lat);
    chk("upg_store_lat", lat, 0);
    cpu_req(1'b1, 1'b0, 32'h44, 32'h0);
    exp_load.push_back(32'h1234);
    wait_hit("ld44", 1'b1, lat);
    chk("ld44_lat", lat, 0);
    cpu_req(1'b1, 1'b1, 32'h40, 32'h00005151);
    wait_hit("both_en_store", 1'b0, lat);
    chk("both_en_lat", lat, 0);
    cpu_req(1'b1, 1'b0, 32'h40, 32'h0);
    exp_load.push_back(32'h00005151);
    wait_hit("ld40_after_store", 1'b1, lat);

    // Conflict load 0xC0: dirty victim written back, then fill
    cpu_req(1'b1, 1'b0, 32'hC0, 32'h0);
    push_wr(32'h40, 32'h00005151); push_wr(32'h44, 32'h1234);
    push_rd(32'hC0, 1'b0); push_rd(32'hC4, 1'b0);
    exp_load.push_back(32'h0000C0C0);
    serve_beat("conf_wb0", 32'h0);
    serve_beat("conf_wb1", 32'h0);
    serve_beat("conf_f0", 32'h0000C0C0);
    serve_beat("conf_f1", 32'h0000C4C4);
    wait_hit("conf_hit", 1'b1, lat);

    // Store 0x44 <- 0x7777 evicting clean 0xC0 block; then snoop with invalidate
    cpu_req(1'b0, 1'b1, 32'h44, 32'h7777);
    push_rd(32'h40, 1'b1); push_rd(32'h44, 1'b1);
    serve_beat("st2_f0", 32'h0000AAAA);
    serve_beat("st2_f1", 32'h00001111);
    wait_hit("st2", 1'b0, lat);
    push_wr(32'h40, 32'h0000AAAA); push_wr(32'h44, 32'h7777);
    snoop("snpM_inv", 32'h44, 1'b1, 1'b1);
    // Frame must now be I: the load misses
    cpu_req(1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge CLK);
    chk1("after_inv_miss", dhit, 1'b0);
    push_rd(32'h40, 1'b0); push_rd(32'h44, 1'b0);
    exp_load.push_back(32'h2222);
    @(posedge CLK);
    #1;
    serve_beat("reld_f0", 32'h1111);
    serve_beat("reld_f1", 32'h2222);
    wait_hit("reld", 1'b1, lat);

    // Dirty again, snoop without invalidate -> frame drops to S
    cpu_req(1'b0, 1'b1, 32'h40, 32'h3333);
    push_rd(32'h40, 1'b1); push_rd(32'h44, 1'b1);
    serve_beat("st3_f0", 32'h1111);
    serve_beat("st3_f1", 32'h2222);
    wait_hit("st3", 1'b0, lat);
    push_wr(32'h40, 32'h3333); push_wr(32'h44, 32'h2222);
    snoop("snpM_shr", 32'h44, 1'b0, 1'b1);
    cpu_req(1'b1, 1'b0, 32'h40, 32'h0);
    exp_load.push_back(32'h3333);
    wait_hit("shared_hit", 1'b1, lat);
    chk("shared_hit_lat", lat, 0);

    // Snoop on S with invalidate: one-cycle response, frame goes I
    snoop("snpS_inv", 32'h40, 1'b1, 1'b0);
    cpu_req(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge CLK);
    chk1("after_sinv_miss", dhit, 1'b0);
    push_rd(32'h40, 1'b0); push_rd(32'h44, 1'b0);
    exp_load.push_back(32'h4444);
    @(posedge CLK);
    #1;
    serve_beat("rl2_f0", 32'h4444);
    serve_beat("rl2_f1", 32'h5555);
    wait_hit("rl2", 1'b1, lat);

    // Snoop on a different tag at the same index: no effect
    snoop("snp_miss", 32'hC0, 1'b1, 1'b0);
    cpu_req(1'b1, 1'b0, 32'h44, 32'h0);
    exp_load.push_back(32'h5555);
    wait_hit("miss_snoop_keep", 1'b1, lat);
    chk("miss_snoop_lat", lat, 0);

    // Abort a fill in FILL0 with a snoop, then restart at word0
    cpu_req(1'b1, 1'b0, 32'h100, 32'h0);
    push_rd(32'h100, 1'b0);
    @(negedge CLK);
    chk1("abort_idle_dREN", dREN, 1'b0);
    @(negedge CLK);
    chk1("abort_fill0_dREN", dREN, 1'b1);
    chk("abort_fill0_daddr", daddr, 32'h100);
    ccwait = 1'b1; ccsnoopaddr = 32'h200; ccinv = 1'b0;
    #1;
    chk1("abort_drop_dREN", dREN, 1'b0);
    @(negedge CLK);
    chk1("abort_snoop_cctrans", cctrans, 1'b1);
    chk1("abort_snoop_ccwrite", ccwrite, 1'b0);
    chk1("abort_snoop_dREN", dREN, 1'b0);
    ccwait = 1'b0;
    @(posedge CLK);
    #1;
    serve_beat("restart_f0", 32'h000000E0);

    // Reset while in FILL1
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk1("midrst_dREN", dREN, 1'b0);
    chk1("midrst_dWEN", dWEN, 1'b0);
    chk1("midrst_dhit", dhit, 1'b0);
    chk1("midrst_cctrans", cctrans, 1'b0);
    chk("midrst_daddr", daddr, 32'h0);
    push_rd(32'h100, 1'b0); push_rd(32'h104, 1'b0);
    exp_load.push_back(32'h000000E4);
    serve_beat("post_rst_f0", 32'h000000E0);
    serve_beat("post_rst_f1", 32'h000000E4);
    cpu_req(1'b1, 1'b0, 32'h104, 32'h0);
    wait_hit("post_rst_hit", 1'b1, lat);

    // Index 8 frame was wiped by reset
    cpu_req(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge CLK);
    chk1("wipe_miss", dhit, 1'b0);
    push_rd(32'h40, 1'b0); push_rd(32'h44, 1'b0);
    exp_load.push_back(32'h6666);
    @(posedge CLK);
    #1;
    serve_beat("wipe_f0", 32'h6666);
    serve_beat("wipe_f1", 32'h7777);
    wait_hit("wipe_hit", 1'b1, lat);

    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("load_queue_drained", exp_load.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
